// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// i_data[0] leaves the line first; each bit is held for CLKS_PER_BIT clocks.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 21812,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         r_reset,
    input  logic [0:7]                   i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic                         o_tx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] DATA_BITS = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    localparam logic [23:0] LAST_CYCLE = 24'(CLKS_PER_BIT - 1);

    logic [0:7]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [23:0]   cycle_cnt;
    logic [3:0]    bit_idx;
    logic [2:0]    next_bit;
    logic [0:7]    shift;
    logic          tx_q;
    logic          bit_end;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        push     = i_valid && !full;
        bit_end  = (cycle_cnt == LAST_CYCLE);
        next_bit = bit_idx[2:0] + 3'd1;
        // The head is consumed either from idle or straight out of the last stop-bit cycle.
        pop      = !empty && ((state == IDLE) || ((state == STOP_BIT) && bit_end));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift     <= mem[rd_ptr];
                        cycle_cnt <= '0;
                        bit_idx   <= '0;
                        tx_q      <= 1'b0;
                        state     <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        cycle_cnt <= '0;
                        bit_idx   <= '0;
                        tx_q      <= shift[0];
                        state     <= DATA_BITS;
                    end else begin
                        cycle_cnt <= cycle_cnt + 24'd1;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        cycle_cnt <= '0;
                        if (bit_idx == 4'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx_q    <= shift[next_bit];
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 24'd1;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        cycle_cnt <= '0;
                        if (!empty) begin
                            shift   <= mem[rd_ptr];
                            bit_idx <= '0;
                            tx_q    <= 1'b0;
                            state   <= START_BIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = !full;
    assign o_tx    = tx_q;
    assign o_busy  = (state != IDLE);
    assign o_done  = (state == STOP_BIT) && bit_end;
    assign o_count = count;

endmodule
